line_window_5row: RTL and testbench

- Upstream feeder for the 5x5 cascaded systolic FIR.
- Accepts a raster-order 8-bit pixel stream and stores the previous four image lines in on-chip line memories.
- Each accepted pixel produces one registered 5-pixel vertical column: rows y-4 to y at the current column.
- Columns go straight onto the FIR's pixel0..pixel4 and in_valid inputs. There is no backpressure, because the FIR accepts one column per cycle.

---
 rtl/line_window_5row_pkg.sv | 9 +
 rtl/line_window_5row_if.sv | 23 ++
 rtl/line_window_5row_line_ram.sv | 24 ++
 rtl/line_window_5row.sv | 78 +++++++
 tb/tb_line_window_5row.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/line_window_5row_pkg.sv
// pkg_img: shared pixel/window constants and default image geometry for the line window feeder.
package pkg_img;
    localparam int PIX_W      = 8;
    localparam int WIN        = 5;
    localparam int LINES      = WIN - 1;
    localparam int SLOT_W     = $clog2(LINES);
    localparam int DEF_WIDTH  = 640;
    localparam int DEF_HEIGHT = 480;
endpackage

// File: rtl/line_window_5row_if.sv
// line_window_5row_if: raster pixel stream in, 5-row column stream out.
interface line_window_5row_if;
    import pkg_img::*;
    logic             in_valid;
    logic [PIX_W-1:0] in_pixel;
    logic             in_sof;
    logic             out_valid;
    logic [PIX_W-1:0] pixel0;
    logic [PIX_W-1:0] pixel1;
    logic [PIX_W-1:0] pixel2;
    logic [PIX_W-1:0] pixel3;
    logic [PIX_W-1:0] pixel4;
    logic             out_eol;
    logic             out_eof;
    modport master (
        output in_valid, in_pixel, in_sof,
        input  out_valid, pixel0, pixel1, pixel2, pixel3, pixel4, out_eol, out_eof
    );
    modport slave (
        input  in_valid, in_pixel, in_sof,
        output out_valid, pixel0, pixel1, pixel2, pixel3, pixel4, out_eol, out_eof
    );
endinterface

// File: rtl/line_window_5row_line_ram.sv
// line_ram: single-port synchronous read-first line memory, one image line deep.
module line_ram
    import pkg_img::*;
#(
    parameter int DEPTH = DEF_WIDTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             en,
    input  logic             we,
    input  logic [AW-1:0]    addr,
    input  logic [PIX_W-1:0] wdata,
    output logic [PIX_W-1:0] rdata
);
    logic [PIX_W-1:0] mem [DEPTH];

    // Read returns the old word on a same-address write: that word is row y-4.
    always_ff @(posedge clk) begin
        if (en) begin
            rdata <= mem[addr];
            if (we) mem[addr] <= wdata;
        end
    end
endmodule

// File: rtl/line_window_5row.sv
// line_window_5row: buffers four previous lines and emits one registered 5-pixel vertical column per accepted pixel.
module line_window_5row
    import pkg_img::*;
#(
    parameter int IMG_WIDTH  = DEF_WIDTH,
    parameter int IMG_HEIGHT = DEF_HEIGHT,
    parameter int COL_W      = $clog2(IMG_WIDTH),
    parameter int ROW_W      = $clog2(IMG_HEIGHT)
) (
    input logic               clk,
    input logic               rst,
    line_window_5row_if.slave bus
);
    logic [COL_W-1:0]  col, cur_col;
    logic [ROW_W-1:0]  row, cur_row;
    logic [SLOT_W-1:0] wr_sel, sel_q;
    logic              filled, last_col, last_row, active;
    logic              valid_q, eol_q, eof_q;
    logic [PIX_W-1:0]  pix4;
    logic [PIX_W-1:0]  rd [LINES];
    logic [PIX_W-1:0]  col_pix [WIN];

    // Start of frame overrides the stored position for the pixel that carries it.
    assign cur_col  = bus.in_sof ? '0 : col;
    assign cur_row  = bus.in_sof ? '0 : row;
    assign last_col = cur_col == COL_W'(IMG_WIDTH - 1);
    assign last_row = cur_row == ROW_W'(IMG_HEIGHT - 1);
    assign active   = cur_row >= ROW_W'(LINES);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col     <= '0;
            row     <= '0;
            wr_sel  <= '0;
            sel_q   <= '0;
            filled  <= 1'b0;
            pix4    <= '0;
            valid_q <= 1'b0;
            eol_q   <= 1'b0;
            eof_q   <= 1'b0;
        end else begin
            valid_q <= bus.in_valid && active;
            eol_q   <= bus.in_valid && active && last_col;
            eof_q   <= bus.in_valid && active && last_col && last_row;
            if (bus.in_valid) begin
                col    <= last_col ? '0 : cur_col + 1'b1;
                row    <= last_col ? (last_row ? '0 : cur_row + 1'b1) : cur_row;
                wr_sel <= wr_sel + SLOT_W'(last_col);
                sel_q  <= wr_sel;
                pix4   <= bus.in_pixel;
                filled <= 1'b1;
            end
        end
    end

    // Slot wr_sel holds the oldest line; the others follow in rotation order.
    for (genvar k = 0; k < LINES; k++) begin : g_slot
        line_ram #(.DEPTH(IMG_WIDTH), .AW(COL_W)) u_ram (
            .clk   (clk),
            .en    (bus.in_valid),
            .we    (bus.in_valid && wr_sel == SLOT_W'(k)),
            .addr  (cur_col),
            .wdata (bus.in_pixel),
            .rdata (rd[k])
        );
        assign col_pix[k] = filled ? rd[sel_q + SLOT_W'(k)] : '0;
    end
    assign col_pix[LINES] = pix4;

    assign bus.out_valid = valid_q;
    assign bus.out_eol   = eol_q;
    assign bus.out_eof   = eof_q;
    assign bus.pixel0    = col_pix[0];
    assign bus.pixel1    = col_pix[1];
    assign bus.pixel2    = col_pix[2];
    assign bus.pixel3    = col_pix[3];
    assign bus.pixel4    = col_pix[4];
endmodule

// File: tb/tb_line_window_5row.sv
// tb_line_window_5row: scoreboard bench for the 5-row line window on an 8x8 image.
module tb_line_window_5row;
    import pkg_img::*;
    localparam int W = 8;
    localparam int H = 8;

    typedef struct packed {
        logic [4:0][7:0] p;
        logic            eol;
        logic            eof;
    } col_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    line_window_5row_if bus();

    line_window_5row #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    col_t sb[$];
    col_t last_exp;
    bit   last_ok = 0;
    bit   exp_v = 0;
    int   checks = 0, errors = 0;
    int   n_out = 0, n_eol = 0, n_eof = 0;
    int   row = 0, col = 0;

    function automatic logic [39:0] got_pix();
        return {bus.pixel4, bus.pixel3, bus.pixel2, bus.pixel1, bus.pixel0};
    endfunction

    task automatic chk(input string name, input logic [39:0] got, input logic [39:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Monitor: the expected valid bit is taken at the edge, the outputs just after it.
    always @(posedge clk) begin : mon
        bit   iv, ev;
        col_t e;
        iv = bus.in_valid;
        ev = exp_v && bus.in_valid;
        #1;
        chk("out_valid", 40'(bus.out_valid), 40'(ev));
        if (bus.out_valid) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_column: got %0h expected none", got_pix());
            end else begin
                e = sb.pop_front();
                chk("column", got_pix(), 40'(e.p));
                chk("eol", 40'(bus.out_eol), 40'(e.eol));
                chk("eof", 40'(bus.out_eof), 40'(e.eof));
                last_exp = e;
                last_ok  = 1;
            end
            n_out++;
            n_eol += int'(bus.out_eol);
            n_eof += int'(bus.out_eof);
        end else begin
            if (iv) last_ok = 0;
            else if (last_ok) chk("hold", got_pix(), 40'(last_exp.p));
            chk("eol_idle", 40'(bus.out_eol), 40'(0));
            chk("eof_idle", 40'(bus.out_eof), 40'(0));
        end
    end

    task automatic send(input logic [7:0] base, input bit sof);
        col_t e;
        if (sof) begin
            row = 0;
            col = 0;
        end
        bus.in_valid = 1'b1;
        bus.in_sof   = sof;
        bus.in_pixel = base + 8'(row * 16 + col);
        exp_v        = row >= 4;
        if (row >= 4) begin
            for (int k = 0; k < 5; k++) e.p[k] = base + 8'((row - 4 + k) * 16 + col);
            e.eol = col == W - 1;
            e.eof = e.eol && row == H - 1;
            sb.push_back(e);
        end
        if (col == W - 1) begin
            col = 0;
            row = (row == H - 1) ? 0 : row + 1;
        end else col++;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        bus.in_valid = 1'b0;
        bus.in_sof   = 1'b0;
        exp_v        = 0;
        repeat (n) @(negedge clk);
    endtask

    task automatic frame(input logic [7:0] base, input bit sof, input bit gaps);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) begin
                send(base, sof && r == 0 && c == 0);
                if (gaps && $urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
            end
    endtask

    task automatic partial(input logic [7:0] base, input int n);
        for (int i = 0; i < n; i++) send(base, i == 0);
    endtask

    task automatic counts(input string tag, input int eo, input int eeol, input int eeof);
        chk({tag, "_out_count"}, 40'(n_out), 40'(eo));
        chk({tag, "_eol_count"}, 40'(n_eol), 40'(eeol));
        chk({tag, "_eof_count"}, 40'(n_eof), 40'(eeof));
        n_out = 0;
        n_eol = 0;
        n_eof = 0;
    endtask

    task automatic zero_outputs(input string tag);
        chk({tag, "_valid"}, 40'(bus.out_valid), 40'(0));
        chk({tag, "_pixels"}, got_pix(), 40'(0));
        chk({tag, "_eol"}, 40'(bus.out_eol), 40'(0));
        chk({tag, "_eof"}, 40'(bus.out_eof), 40'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_valid = 1'b0;
        bus.in_sof   = 1'b0;
        bus.in_pixel = '0;
        repeat (2) @(negedge clk);
        zero_outputs("reset");
        rst = 1'b1;
        @(negedge clk);
        frame(8'h00, 1, 0);
        idle(2);
        counts("frame1", 32, 4, 1);
        frame(8'h00, 1, 1);
        idle(2);
        counts("gapped", 32, 4, 1);
        frame(8'h00, 1, 0);
        frame(8'h80, 1, 0);
        idle(2);
        counts("b2b", 64, 8, 2);
        partial(8'h00, 5 * W + 3);
        frame(8'h01, 1, 0);
        idle(2);
        counts("midsof", 43, 5, 1);
        partial(8'h00, 6 * W + 3);
        idle(1);
        #2 rst = 1'b0;
        #1 zero_outputs("async_rst");
        #1 rst = 1'b1;
        row     = 0;
        col     = 0;
        last_ok = 0;
        @(negedge clk);
        frame(8'h08, 0, 0);
        idle(3);
        counts("after_rst", 51, 6, 1);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL leftover: got %0d pending columns expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
